// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - slot-based arbiter between downloader, eraser, CPU and the SDRAM controller
//
// Purpose:
//   Latches one pending request per port and runs at most one SDRAM access per clkref slot.
//   Each access starts on a clkref rising edge. It holds addr/din/we/oe for SLOT_CYCLES cycles
//   and ends with a one-cycle acknowledge to the port that was granted. CPU read data is sampled
//   at slot cycle SAMPLE_AT and held until the next CPU read completes.
//
// Ports:
//   sys_clock, reset_n             clock, asynchronous active-low reset
//   clkref                         SDRAM phase reference; a slot starts on its rising edge
//   dl_req/dl_addr/dl_data/dl_ack  downloader write port (request pulse, completion pulse)
//   er_req/er_addr/er_data/er_ack  eraser write port
//   cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_rdata/cpu_ack  CPU read/write port
//   sd_addr/sd_din/sd_we/sd_oe     drive the controller; sd_dout is its read data
//   busy                           high while a slot is in progress
//   overflow                       sticky, set when a request hits a port that is already pending
//
// Optional feature macro: SDRAM_ARB_ROUND_ROBIN_EN
//   When defined, the eraser and the CPU share round-robin priority.
//   The downloader always keeps top priority.
module sdram_port_arbiter #(
  parameter int SLOT_CYCLES = 8,
  parameter int SAMPLE_AT   = 6   // must be < SLOT_CYCLES
) (
  input  logic        sys_clock,
  input  logic        reset_n,
  input  logic        clkref,
  input  logic        dl_req,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_ack,
  input  logic        er_req,
  input  logic [24:0] er_addr,
  input  logic [7:0]  er_data,
  output logic        er_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [24:0] sd_addr,
  output logic [7:0]  sd_din,
  output logic        sd_we,
  output logic        sd_oe,
  input  logic [7:0]  sd_dout,
  output logic        busy,
  output logic        overflow
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_AT);

  typedef enum logic {S_IDLE, S_SLOT} state_t;
  typedef enum logic [1:0] {G_DL, G_ER, G_CPU} gnt_t;

  state_t        state_q, state_d;
  gnt_t          gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clkref_q;

  logic          dl_pend_q, dl_pend_d, er_pend_q, er_pend_d, cpu_pend_q, cpu_pend_d;
  logic [24:0]   dl_addr_q, dl_addr_d, er_addr_q, er_addr_d;
  logic [7:0]    dl_data_q, dl_data_d, er_data_q, er_data_d;
  logic [15:0]   cpu_addr_q, cpu_addr_d;
  logic [7:0]    cpu_wdata_q, cpu_wdata_d;
  logic          cpu_we_q, cpu_we_d;

  logic [24:0]   sd_addr_q, sd_addr_d;
  logic [7:0]    sd_din_q, sd_din_d, cpu_rdata_q, cpu_rdata_d;
  logic          sd_we_q, sd_we_d, sd_oe_q, sd_oe_d, busy_q, busy_d, overflow_q, overflow_d;
  logic          dl_ack_q, dl_ack_d, er_ack_q, er_ack_d, cpu_ack_q, cpu_ack_d;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  gnt_t          last_q, last_d;   // last of eraser/CPU to be granted
`endif

  logic clkref_rise, slot_end, dl_clr, er_clr, cpu_clr, dl_avail, er_avail, cpu_avail;
  logic pick_valid;
  gnt_t pick;

  assign clkref_rise = clkref & ~clkref_q;
  assign slot_end    = (state_q == S_SLOT) && (cnt_q == CNT_LAST);
  assign dl_clr      = slot_end && (gnt_q == G_DL);
  assign er_clr      = slot_end && (gnt_q == G_ER);
  assign cpu_clr     = slot_end && (gnt_q == G_CPU);
  // The pending bit of the port that completes this cycle counts as already free. A request
  // arriving together with its own completion is therefore accepted, not treated as overflow.
  assign dl_avail    = dl_pend_q & ~dl_clr;
  assign er_avail    = er_pend_q & ~er_clr;
  assign cpu_avail   = cpu_pend_q & ~cpu_clr;
  assign pick_valid  = dl_avail | er_avail | cpu_avail;

  always_comb begin
    pick = G_DL;
    if (dl_avail) pick = G_DL;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    else if (er_avail && cpu_avail) pick = (last_q == G_ER) ? G_CPU : G_ER;
`endif
    else if (er_avail) pick = G_ER;
    else pick = G_CPU;
  end

  always_comb begin
    state_d = state_q;       gnt_d = gnt_q;           cnt_d = cnt_q;
    dl_addr_d = dl_addr_q;   dl_data_d = dl_data_q;
    er_addr_d = er_addr_q;   er_data_d = er_data_q;
    cpu_addr_d = cpu_addr_q; cpu_wdata_d = cpu_wdata_q; cpu_we_d = cpu_we_q;
    sd_addr_d = sd_addr_q;   sd_din_d = sd_din_q;     sd_we_d = sd_we_q;  sd_oe_d = sd_oe_q;
    busy_d = busy_q;         cpu_rdata_d = cpu_rdata_q;
    dl_ack_d = 1'b0;         er_ack_d = 1'b0;         cpu_ack_d = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    last_d = last_q;
`endif

    dl_pend_d  = dl_avail | dl_req;
    er_pend_d  = er_avail | er_req;
    cpu_pend_d = cpu_avail | cpu_req;
    overflow_d = overflow_q | (dl_req & dl_avail) | (er_req & er_avail) | (cpu_req & cpu_avail);
    if (dl_req && !dl_avail) begin
      dl_addr_d = dl_addr;
      dl_data_d = dl_data;
    end
    if (er_req && !er_avail) begin
      er_addr_d = er_addr;
      er_data_d = er_data;
    end
    if (cpu_req && !cpu_avail) begin
      cpu_addr_d  = cpu_addr;
      cpu_wdata_d = cpu_wdata;
      cpu_we_d    = cpu_we;
    end

    case (state_q)
      S_IDLE: ;
      S_SLOT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_SAMPLE && gnt_q == G_CPU && !sd_we_q) cpu_rdata_d = sd_dout;
        if (slot_end) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          sd_we_d   = 1'b0;
          sd_oe_d   = 1'b0;
          busy_d    = 1'b0;
          dl_ack_d  = dl_clr;
          er_ack_d  = er_clr;
          cpu_ack_d = cpu_clr;
        end
      end
      default: ;
    endcase

    // The last slot cycle coincides with the next clkref rise when clkref has exactly
    // SLOT_CYCLES cycles. In that case the next slot is granted directly, with no idle cycle.
    if (clkref_rise && pick_valid && (state_q == S_IDLE || slot_end)) begin
      state_d = S_SLOT;
      gnt_d   = pick;
      cnt_d   = '0;
      busy_d  = 1'b1;
      case (pick)
        G_DL: begin
          sd_addr_d = dl_addr_q; sd_din_d = dl_data_q; sd_we_d = 1'b1; sd_oe_d = 1'b0;
        end
        G_ER: begin
          sd_addr_d = er_addr_q; sd_din_d = er_data_q; sd_we_d = 1'b1; sd_oe_d = 1'b0;
        end
        default: begin
          sd_addr_d = {9'd0, cpu_addr_q}; sd_din_d = cpu_wdata_q;
          sd_we_d   = cpu_we_q;           sd_oe_d  = ~cpu_we_q;
        end
      endcase
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      if (pick != G_DL) last_d = pick;
`endif
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;   gnt_q <= G_DL;        cnt_q <= '0;       clkref_q <= 1'b0;
      dl_pend_q <= 1'b0;   er_pend_q <= 1'b0;    cpu_pend_q <= 1'b0;
      dl_addr_q <= '0;     dl_data_q <= '0;      er_addr_q <= '0;   er_data_q <= '0;
      cpu_addr_q <= '0;    cpu_wdata_q <= '0;    cpu_we_q <= 1'b0;
      sd_addr_q <= '0;     sd_din_q <= '0;       sd_we_q <= 1'b0;   sd_oe_q <= 1'b0;
      busy_q <= 1'b0;      overflow_q <= 1'b0;   cpu_rdata_q <= '0;
      dl_ack_q <= 1'b0;    er_ack_q <= 1'b0;     cpu_ack_q <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last_q <= G_CPU;     // the eraser wins the first eraser/CPU tie
`endif
    end else begin
      state_q <= state_d;  gnt_q <= gnt_d;       cnt_q <= cnt_d;    clkref_q <= clkref;
      dl_pend_q <= dl_pend_d; er_pend_q <= er_pend_d; cpu_pend_q <= cpu_pend_d;
      dl_addr_q <= dl_addr_d; dl_data_q <= dl_data_d; er_addr_q <= er_addr_d; er_data_q <= er_data_d;
      cpu_addr_q <= cpu_addr_d; cpu_wdata_q <= cpu_wdata_d; cpu_we_q <= cpu_we_d;
      sd_addr_q <= sd_addr_d; sd_din_q <= sd_din_d; sd_we_q <= sd_we_d; sd_oe_q <= sd_oe_d;
      busy_q <= busy_d;    overflow_q <= overflow_d; cpu_rdata_q <= cpu_rdata_d;
      dl_ack_q <= dl_ack_d; er_ack_q <= er_ack_d; cpu_ack_q <= cpu_ack_d;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last_q <= last_d;
`endif
    end
  end

  assign sd_addr   = sd_addr_q;
  assign sd_din    = sd_din_q;
  assign sd_we     = sd_we_q;
  assign sd_oe     = sd_oe_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dl_ack    = dl_ack_q;
  assign er_ack    = er_ack_q;
  assign cpu_ack   = cpu_ack_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter
//
// Purpose:
//   Drives directed request sequences against an 8-cycle clkref and checks them.
//   A small byte memory stands in for the SDRAM controller. Inputs change 1 ns after the
//   rising edge, and outputs are sampled at that point too. The bench variable ph is the
//   slot phase of the current cycle, and the clkref rise falls in the ph==0 cycle.
// Ports: none (top-level bench).
module tb_sdram_port_arbiter;

  logic        sys_clock, reset_n, clkref;
  logic        dl_req, er_req, cpu_req, cpu_we;
  logic [24:0] dl_addr, er_addr;
  logic [7:0]  dl_data, er_data, cpu_wdata;
  logic [15:0] cpu_addr;
  logic        dl_ack, er_ack, cpu_ack, sd_we, sd_oe, busy, overflow;
  logic [7:0]  cpu_rdata, sd_din, sd_dout;
  logic [24:0] sd_addr;

  int errors = 0;
  int checks = 0;
  int ph = 7;
  int acks, busys;
  logic [7:0] mem [0:4095];

  sdram_port_arbiter dut (
    .sys_clock(sys_clock), .reset_n(reset_n), .clkref(clkref),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
    .er_req(er_req), .er_addr(er_addr), .er_data(er_data), .er_ack(er_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_oe(sd_oe), .sd_dout(sd_dout),
    .busy(busy), .overflow(overflow)
  );

  initial begin
    sys_clock = 1'b0;
    forever #5 sys_clock = ~sys_clock;
  end

  always @(posedge sys_clock) if (sd_we) mem[sd_addr[11:0]] <= sd_din;
  assign sd_dout = sd_oe ? mem[sd_addr[11:0]] : 8'hEE;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clock);
      #1;
      ph = (ph + 1) % 8;
      clkref = (ph < 4);
    end
  endtask

  task automatic to_ph(input int k);
    do tick(1); while (ph != k);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; clkref = 1'b0;
    dl_req = 0; er_req = 0; cpu_req = 0; cpu_we = 0;
    dl_addr = '0; er_addr = '0; dl_data = '0; er_data = '0; cpu_addr = '0; cpu_wdata = '0;

    tick(3);
    chk("rst_sd_addr", sd_addr, 0);   chk("rst_sd_we", sd_we, 0);   chk("rst_sd_oe", sd_oe, 0);
    chk("rst_busy", busy, 0);         chk("rst_overflow", overflow, 0);
    chk("rst_rdata", cpu_rdata, 0);   chk("rst_acks", {dl_ack, er_ack, cpu_ack}, 0);
    reset_n = 1'b1;

    // CPU write 0x5A to 0x8241
    to_ph(2);
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h8241; cpu_wdata = 8'h5A;
    tick(); cpu_req = 0;
    to_ph(1);
    chk("wr_addr", sd_addr, 25'h8241); chk("wr_din", sd_din, 8'h5A);
    chk("wr_we_c0", sd_we, 1);         chk("wr_oe", sd_oe, 0); chk("wr_busy", busy, 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("wr_we_slot", sd_we, 1);
      chk("wr_noack_slot", cpu_ack, 0);
    end
    tick();
    chk("wr_ack", cpu_ack, 1); chk("wr_we_end", sd_we, 0); chk("wr_busy_end", busy, 0);

    // CPU read back from 0x8241
    to_ph(2);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h8241;
    tick(); cpu_req = 0;
    to_ph(1);
    chk("rd_oe", sd_oe, 1); chk("rd_we", sd_we, 0); chk("rd_addr", sd_addr, 25'h8241);
    to_ph(6);
    chk("rd_rdata_before_sample", cpu_rdata, 0);
    to_ph(1);
    chk("rd_ack", cpu_ack, 1); chk("rd_rdata_at_ack", cpu_rdata, 8'h5A); chk("rd_oe_end", sd_oe, 0);
    tick();
    chk("rd_ack_pulse", cpu_ack, 0); chk("rd_rdata_hold", cpu_rdata, 8'h5A);

    // Contention: all three ports in the same cycle
    to_ph(2);
    dl_req = 1; dl_addr = 25'h00010; dl_data = 8'h11;
    er_req = 1; er_addr = 25'h00020; er_data = 8'h22;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 8'h33;
    tick(); dl_req = 0; er_req = 0; cpu_req = 0;
    to_ph(1);
    chk("ct_dl_addr", sd_addr, 25'h10); chk("ct_dl_din", sd_din, 8'h11); chk("ct_dl_we", sd_we, 1);
    tick(8);
    chk("ct_dl_ack", dl_ack, 1); chk("ct_er_addr", sd_addr, 25'h20);
    chk("ct_er_din", sd_din, 8'h22); chk("ct_er_busy", busy, 1);
    tick();
    chk("ct_dl_ack_pulse", dl_ack, 0);
    tick(7);
    chk("ct_er_ack", er_ack, 1); chk("ct_cpu_addr", sd_addr, 25'h30); chk("ct_cpu_we", sd_we, 1);
    tick(8);
    chk("ct_cpu_ack", cpu_ack, 1); chk("ct_busy_end", busy, 0); chk("ct_overflow", overflow, 0);

    // Eraser alone, then an eraser/CPU tie
    to_ph(2);
    er_req = 1; er_addr = 25'h40; er_data = 8'h44;
    tick(); er_req = 0;
    to_ph(1);
    chk("tie_pre_addr", sd_addr, 25'h40);
    to_ph(1);
    chk("tie_pre_ack", er_ack, 1);
    er_req = 1; er_addr = 25'h50; er_data = 8'h55;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0060; cpu_wdata = 8'h66;
    tick(); er_req = 0; cpu_req = 0;
    to_ph(1);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    chk("tie_first", sd_addr, 25'h60);
    tick(8);
    chk("tie_second", sd_addr, 25'h50); chk("tie_first_ack", cpu_ack, 1);
    tick(8);
    chk("tie_second_ack", er_ack, 1);
`else
    chk("tie_first", sd_addr, 25'h50);
    tick(8);
    chk("tie_second", sd_addr, 25'h60); chk("tie_first_ack", er_ack, 1);
    tick(8);
    chk("tie_second_ack", cpu_ack, 1);
`endif
    chk("tie_overflow", overflow, 0);

    // Eraser re-request in the cycle its slot ends
    to_ph(2);
    er_req = 1; er_addr = 25'h70; er_data = 8'h77;
    tick(); er_req = 0;
    to_ph(1);
    chk("rr_first_addr", sd_addr, 25'h70);
    to_ph(0);
    er_req = 1; er_addr = 25'h71; er_data = 8'h78;
    tick(); er_req = 0;
    chk("rr_first_ack", er_ack, 1); chk("rr_overflow", overflow, 0); chk("rr_gap_busy", busy, 0);
    to_ph(1);
    chk("rr_second_addr", sd_addr, 25'h71); chk("rr_second_din", sd_din, 8'h78);
    chk("rr_second_busy", busy, 1);
    to_ph(1);
    chk("rr_second_ack", er_ack, 1);

    // Overflow: second CPU request while the first is still pending
    to_ph(2);
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0100; cpu_wdata = 8'hA1;
    tick(); cpu_req = 0;
    tick(); cpu_req = 1; cpu_addr = 16'h0200; cpu_wdata = 8'hA2;
    tick(); cpu_req = 0;
    chk("ov_flag", overflow, 1);
    to_ph(1);
    chk("ov_addr", sd_addr, 25'h100); chk("ov_din", sd_din, 8'hA1);
    acks = 0; busys = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (cpu_ack) acks++;
      if (busy) busys++;
    end
    chk("ov_ack_count", acks, 1); chk("ov_busy_cycles", busys, 7); chk("ov_sticky", overflow, 1);

    // Idle: outputs hold, no strobes
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_strobes", {sd_we, sd_oe, busy}, 0);
      chk("idle_addr_hold", sd_addr, 25'h100);
      chk("idle_din_hold", sd_din, 8'hA1);
      chk("idle_rdata_hold", cpu_rdata, 8'h5A);
    end

    // Reset in the middle of a CPU write
    to_ph(2);
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0300; cpu_wdata = 8'hB3;
    tick(); cpu_req = 0;
    to_ph(1);
    tick(3);
    chk("mr_we_cnt3", sd_we, 1); chk("mr_busy_cnt3", busy, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("mr_we", sd_we, 0); chk("mr_busy", busy, 0); chk("mr_ack", cpu_ack, 0);
    chk("mr_addr", sd_addr, 0); chk("mr_overflow", overflow, 0);
    tick(2);
    reset_n = 1'b1;
    acks = 0; busys = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (cpu_ack) acks++;
      if (busy) busys++;
    end
    chk("mr_no_ack", acks, 0); chk("mr_no_busy", busys, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Sequential arbiter between the ROM/PRG downloader, the RAM eraser and the Z80 bus, and the single-port SDRAM controller. It sits directly upstream of `sdram` and replaces the combinational source mux with latched requests, one access per `clkref` slot, and explicit acknowledges. Read data is captured and held for the CPU, so requesters never see the controller's raw, slot-varying `dout`.

## Interface
Parameters:
- `SLOT_CYCLES`, 8: `sys_clock` cycles per SDRAM slot (one `clkref` period).
- `SAMPLE_AT`, 6: slot cycle index (0-based) at which `sd_dout` is captured for reads; must be < `SLOT_CYCLES`.

Ports:
- `sys_clock` in 1: sole clock, all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `clkref` in 1: SDRAM phase reference (cpu_clock); a slot starts on its rising edge.
- `dl_req` in 1: downloader request pulse (1 cycle).
- `dl_addr` in 25: downloader byte address.
- `dl_data` in 8: downloader write data. Downloader accesses are always writes.
- `dl_ack` out 1: 1-cycle pulse at downloader access completion.
- `er_req` in 1: eraser request pulse.
- `er_addr` in 25: eraser byte address.
- `er_data` in 8: eraser write data. Eraser accesses are always writes.
- `er_ack` out 1: eraser completion pulse.
- `cpu_req` in 1: CPU request pulse.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 16: CPU address, zero-extended to 25 bits.
- `cpu_wdata` in 8: CPU write data.
- `cpu_rdata` out 8: last captured CPU read byte, held until the next CPU read completes.
- `cpu_ack` out 1: CPU completion pulse.
- `sd_addr` out 25, `sd_din` out 8, `sd_we` out 1, `sd_oe` out 1: drive the controller's `addr`/`din`/`we`/`oe`.
- `sd_dout` in 8: controller read data.
- `busy` out 1: high while a slot is in progress.
- `overflow` out 1: sticky; set when any `*_req` arrives while that port is already pending.

## Operation
- Each port has a pending bit plus a latch for addr/data/we.
  - `*_req` with the port not pending: set pending and latch the inputs.
  - `*_req` with the port already pending: the request is dropped, the latch is unchanged, and `overflow` is set.
  - Requests never need to be held; only the pulse matters.
- `clkref_rise` = `clkref` & ~`clkref` delayed one cycle.
- FSM states: IDLE and SLOT.
  - IDLE → SLOT when `clkref_rise` is high and any port is pending.
  - On that transition: grant the winning port, load `sd_addr`/`sd_din` from its latch, set `sd_we` = latched we and `sd_oe` = ~latched we, set `busy` = 1, and set slot counter `cnt` = 0.
  - SLOT: `cnt` increments every cycle.
  - At `cnt` == `SAMPLE_AT`, if the grant is CPU with a read, `cpu_rdata` ← `sd_dout`.
  - At `cnt` == `SLOT_CYCLES`-1: clear `sd_we`, `sd_oe` and `busy`; clear the granted pending bit; pulse the granted `*_ack` on the next cycle; go to IDLE.
  - `sd_addr`/`sd_din` hold their last values in IDLE.
- Priority is fixed: downloader > eraser > CPU, evaluated at grant time only. There is no preemption during a slot.
- Simultaneous new `*_req` and completion on the same port in the same cycle: the completion clears the old pending bit first, then the new request sets it. The new request is accepted and does not count as overflow.
- Requests arriving during SLOT are latched and compete at the next `clkref_rise`.

## Timing
- Reset values: `sd_addr`=0, `sd_din`=0, `sd_we`=0, `sd_oe`=0, all acks 0, `cpu_rdata`=0, `busy`=0, `overflow`=0, all pending bits 0, FSM in IDLE, `cnt`=0.
- `reset_n` asserted mid-slot forces the reset values immediately (asynchronously). The interrupted access is abandoned and no ack is issued.
- Latency: grant occurs on the first `clkref_rise` at least one cycle after the `*_req` pulse.
- The ack pulse comes `SLOT_CYCLES` cycles after the grant edge. Worst case from request to ack is 2×`SLOT_CYCLES`+1 cycles for the highest-priority port.
- With the default 8-cycle `clkref`, back-to-back slots are possible: SLOT ends on `cnt`=7 and the next `clkref_rise` follows on the next cycle.
- `cpu_rdata` is valid on the cycle `cpu_ack` is high and remains stable afterwards.

## Configuration
- `SDRAM_ARB_ROUND_ROBIN_EN`:
  - Defined: the eraser and CPU share round-robin priority. The port not granted last wins ties. The downloader still has absolute priority.
  - Undefined: fixed priority downloader > eraser > CPU as described above. Under a continuous eraser stream the CPU can starve, which is acceptable because the CPU is held in WAIT/RESET during erase.

## Test plan
- CPU write then read: `cpu_req` write to addr 0x8241 with data 0x5A, then a read of 0x8241 against a model returning 0x5A. Required: `sd_we`=1 for cycles 0–7 of the first slot; `cpu_ack` one cycle after; `cpu_rdata`=0x5A at the second `cpu_ack`.
- Contention: `dl_req` (addr 0x00010), `er_req` and `cpu_req` all in the same cycle. Required: grant order dl, er, cpu in three consecutive slots, acks spaced 8 cycles apart. With `SDRAM_ARB_ROUND_ROBIN_EN` defined and er granted last, a subsequent er/cpu tie grants cpu.
- Overflow: two `cpu_req` pulses 2 cycles apart before grant. Required: `overflow`=1, the first address is accessed, and exactly one `cpu_ack` is issued.
- Re-request on ack: `er_req` in the same cycle the eraser's slot ends. Required: `overflow` stays 0 and a second eraser slot starts at the next `clkref_rise`.
- Reset mid-slot: `reset_n` low at `cnt`=3 of a CPU write. Required: `sd_we`=0, `busy`=0 and `cpu_ack`=0 immediately; no ack appears after release.
- Idle: no requests for 100 cycles. Required: `sd_we`=`sd_oe`=`busy`=0 throughout, and outputs hold their last values.
